// File: rtl/ahb_lite_master_if_pkg.sv
// Shared definitions for the AHB-Lite master interface.
// Holds the bus FSM state type, htrans/hprot encodings, funct3 size and
// sign constants, and the alignment check used by the request front end.
package ahb_lite_master_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR2
  } bus_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // funct3[1:0] is the access size, funct3[2] selects zero-extension
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  localparam int unsigned FN3_UNSIGNED_BIT = 2;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = |addr_lo[1:0];
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_wbuf_fifo.sv
// Posted-write buffer: a small synchronous FIFO.
// Ports: push/din write an entry, pop retires the head, dout shows the head,
// full/empty report occupancy. Push and pop in the same cycle are both
// honoured, including when full. Pointers wrap modulo DEPTH.
module ahb_wbuf_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite master for a RISC-V style load/store port.
// Core side: req_* request handshake (stores are posted through a write
// buffer, loads wait for it to drain), rsp_* load completion, sticky wr_err
// for posted-write failures, wbuf_empty status.
// Bus side: single NONSEQ transfers, stores may overlap the previous data
// phase; two-cycle ERROR responses cancel any overlapped address.
module ahb_lite_master_if
  import ahb_lite_master_if_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_fn3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err,
  input  logic              wr_err_clr,
  output logic              wbuf_empty,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned EW     = ADDR_W + 2 + DATA_W;

  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    int unsigned span;
    r    = '0;
    span = 32'd1 << sz;
    for (int unsigned i = 0; i < NB; i++)
      r = r | (DATA_W'(8'(d >> ((i % span) * 8))) << (i * 8));
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                    input logic [LANE_W-1:0] lane,
                                                    input logic [2:0] fn3);
    logic [DATA_W-1:0] sh, mask, top;
    int unsigned nbits;
    logic fill;
    sh    = d >> {lane, 3'b000};
    nbits = 32'd8 << fn3[1:0];
    if (nbits > DATA_W) nbits = DATA_W;
    mask  = (nbits >= DATA_W) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
    top   = sh >> (nbits - 1);
    fill  = !fn3[FN3_UNSIGNED_BIT] && top[0];
    return (sh & mask) | ({DATA_W{fill}} & ~mask);
  endfunction

  bus_state_e state, state_nx;
  logic              run;
  logic              ld_pend, mis_pend;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_fn3;
  logic              d_write;
  logic [2:0]        d_fn3;
  logic [LANE_W-1:0] d_lane;
  logic [DATA_W-1:0] d_wdata;

  logic              f_push, f_pop, f_full, f_empty;
  logic [EW-1:0]     f_din, f_dout;
  logic [ADDR_W-1:0] head_addr;
  logic [1:0]        head_size;
  logic [DATA_W-1:0] head_wdata;

  logic in_flight, ld_busy, ld_ok, req_mis, acc;
  logic ld_acc, mis_ld, mis_st, wr_err_set;
  logic overlap, addr_phase, src_load;

  assign {head_addr, head_size, head_wdata} = f_dout;

  assign req_mis    = is_misaligned(req_fn3[1:0], req_addr[2:0]);
  assign in_flight  = (state == DATA) || (state == ERR2);
  assign wbuf_empty = f_empty && !(in_flight && d_write);
  assign ld_busy    = ld_pend || mis_pend || (in_flight && !d_write);
  assign ld_ok      = wbuf_empty && !ld_busy;

  // Next buffered store overlaps the current data phase; an ERROR first
  // cycle withdraws it so the slave never sees it.
  assign overlap    = (state == DATA) && !f_empty && !hresp;
  assign addr_phase = (state == ADDR) || overlap;
  assign src_load   = (state == ADDR) && ld_pend;
  assign f_pop      = addr_phase && hready && !src_load;

  assign req_ready  = run && (req_write ? (req_mis || !f_full || f_pop) : ld_ok);
  assign acc        = req_valid && req_ready;
  assign f_push     = acc && req_write && !req_mis;
  assign ld_acc     = acc && !req_write && !req_mis;
  assign mis_ld     = acc && !req_write && req_mis;
  assign mis_st     = acc && req_write && req_mis;
  assign wr_err_set = mis_st || ((state == ERR2) && d_write);
  assign f_din      = {req_addr, req_fn3[1:0], replicate(req_wdata, req_fn3[1:0])};

  ahb_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (EW)
  ) u_wbuf (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   (f_din),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // An overlapped address accepted with the closing hready is already in
  // its data phase, so DATA is re-entered rather than re-issuing it in ADDR.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!f_empty || ld_acc) state_nx = ADDR;
      ADDR: if (hready) state_nx = DATA;
      DATA: begin
        if (hready) begin
          if (overlap)                 state_nx = DATA;
          else if (!f_empty || f_push) state_nx = ADDR;
          else                         state_nx = IDLE;
        end else if (hresp) begin
          state_nx = ERR2;
        end
      end
      ERR2:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      ld_pend  <= 1'b0;
      ld_addr  <= '0;
      ld_fn3   <= '0;
      mis_pend <= 1'b0;
      d_write  <= 1'b0;
      d_fn3    <= '0;
      d_lane   <= '0;
      d_wdata  <= '0;
      wr_err   <= 1'b0;
    end else begin
      run      <= 1'b1;
      mis_pend <= mis_ld;
      if (ld_acc) begin
        ld_pend <= 1'b1;
        ld_addr <= req_addr;
        ld_fn3  <= req_fn3;
      end else if (src_load && hready) begin
        ld_pend <= 1'b0;
      end
      if (addr_phase && hready) begin
        d_write <= !src_load;
        d_fn3   <= src_load ? ld_fn3 : {1'b0, head_size};
        d_lane  <= src_load ? ld_addr[LANE_W-1:0] : head_addr[LANE_W-1:0];
        d_wdata <= src_load ? '0 : head_wdata;
      end
      if (wr_err_set)      wr_err <= 1'b1;
      else if (wr_err_clr) wr_err <= 1'b0;
    end
  end

  assign htrans    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = addr_phase ? (src_load ? ld_addr : head_addr) : '0;
  assign hwrite    = addr_phase && !src_load;
  assign hsize     = addr_phase ? {1'b0, (src_load ? ld_fn3[1:0] : head_size)} : '0;
  assign hprot     = HPROT_DEFAULT;
  assign hwdata    = d_wdata;

  assign rsp_valid = mis_pend || ((state == ERR2) && !d_write) ||
                     ((state == DATA) && hready && !hresp && !d_write);
  assign rsp_err   = mis_pend || ((state == ERR2) && !d_write);
  assign rsp_rdata = ((state == DATA) && !d_write) ? load_extend(hrdata, d_lane, d_fn3) : '0;

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Directed self-checking bench for ahb_lite_master_if (32-bit, 2-entry buffer).
// The bench plays the AHB slave by hand, cycle by cycle.
module tb_ahb_lite_master_if;

  logic        clk, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_fn3;
  logic        rsp_valid, rsp_err, wr_err, wr_err_clr, wbuf_empty;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ahb_lite_master_if #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .WBUF_DEPTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_fn3    (req_fn3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wr_err     (wr_err),
    .wr_err_clr (wr_err_clr),
    .wbuf_empty (wbuf_empty),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hprot      (hprot),
    .hwdata     (hwdata),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_htrans"}, htrans, 2'b00);
    check({tag, "_haddr"}, haddr, 32'h0);
    check({tag, "_hwdata"}, hwdata, 32'h0);
    check({tag, "_hsize"}, hsize, 3'd0);
    check({tag, "_hwrite"}, hwrite, 1'b0);
    check({tag, "_hprot"}, hprot, 4'b0011);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_wr_err"}, wr_err, 1'b0);
    check({tag, "_wbuf_empty"}, wbuf_empty, 1'b1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] fn3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    int unsigned n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_fn3 = fn3;
    #1;
    while (!req_ready && n < 10) begin step(); n++; end
    check({tag, "_acc"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    #1;
    n = 0;
    while (htrans !== 2'b10 && n < 10) begin step(); n++; end
    check({tag, "_haddr"}, haddr, addr);
    check({tag, "_hsize"}, hsize, {1'b0, fn3[1:0]});
    step();
    hrdata = rdata;
    #1;
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rdata"}, rsp_rdata, exp);
    step();
    hrdata = 32'h0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] fn3,
                          input logic [31:0] wdata, input logic [31:0] exp);
    int unsigned n = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_fn3 = fn3; req_wdata = wdata;
    #1;
    while (!req_ready && n < 10) begin step(); n++; end
    check({tag, "_acc"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    #1;
    n = 0;
    while (htrans !== 2'b10 && n < 10) begin step(); n++; end
    check({tag, "_haddr"}, haddr, addr);
    check({tag, "_hsize"}, hsize, {1'b0, fn3[1:0]});
    check({tag, "_hwrite"}, hwrite, 1'b1);
    step();
    #1;
    check({tag, "_hwdata"}, hwdata, exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_fn3 = '0;
    req_wdata = '0; wr_err_clr = 1'b0; hready = 1'b0; hresp = 1'b0; hrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_fn3 = 3'b010;
    req_wdata = 32'hDEADBEEF;
    #1 check_reset("rst");
    hready = 1'b1;
    reset  = 1'b1;
    #1 check("release_ready", req_ready, 1'b0);

    // SW then LW to 0x100
    step(); #1 check("sw_ready", req_ready, 1'b1);
    step(); req_write = 1'b0;
    #1 check("lw_blocked_idle", req_ready, 1'b0);
    check("sw_idle_htrans", htrans, 2'b00);
    step(); #1 check("sw_htrans", htrans, 2'b10);
    check("sw_haddr", haddr, 32'h100);
    check("sw_hwrite", hwrite, 1'b1);
    check("sw_hsize", hsize, 3'd2);
    check("lw_blocked_addr", req_ready, 1'b0);
    step(); #1 check("sw_hwdata", hwdata, 32'hDEADBEEF);
    check("sw_data_htrans", htrans, 2'b00);
    check("lw_blocked_data", req_ready, 1'b0);
    step(); #1 check("lw_ready", req_ready, 1'b1);
    check("lw_wbuf_empty", wbuf_empty, 1'b1);
    step(); req_valid = 1'b0;
    #1 check("lw_htrans", htrans, 2'b10);
    check("lw_haddr", haddr, 32'h100);
    check("lw_hwrite", hwrite, 1'b0);
    step(); hrdata = 32'hDEADBEEF;
    #1 check("lw_rsp_valid", rsp_valid, 1'b1);
    check("lw_rdata", rsp_rdata, 32'hDEADBEEF);
    check("lw_rsp_err", rsp_err, 1'b0);
    step(); hrdata = 32'h0;
    #1 check("lw_rsp_done", rsp_valid, 1'b0);

    // lane selection and extension
    do_load("lb",  32'h103, 3'b000, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load("lbu", 32'h103, 3'b100, 32'h80FF_FF00, 32'h0000_0080);
    do_load("lh",  32'h102, 3'b001, 32'h80FF_FF00, 32'hFFFF_80FF);
    do_load("lhu", 32'h102, 3'b101, 32'h80FF_FF00, 32'h0000_80FF);

    // store lane replication
    do_store("sb", 32'h105, 3'b000, 32'h0000_00A5, 32'hA5A5_A5A5);
    do_store("sh", 32'h106, 3'b001, 32'h0000_1234, 32'h1234_1234);

    // three stores, full buffer, address held in wait states
    req_valid = 1'b1; req_write = 1'b1; req_fn3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h1111_1111;
    #1 check("w3_sw1_ready", req_ready, 1'b1);
    step(); req_addr = 32'h204; req_wdata = 32'h2222_2222;
    #1 check("w3_sw2_ready", req_ready, 1'b1);
    step(); req_addr = 32'h208; req_wdata = 32'h3333_3333; hready = 1'b0;
    #1 check("w3_sw3_stall", req_ready, 1'b0);
    check("w3_haddr", haddr, 32'h200);
    check("w3_htrans", htrans, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check("w3_sw3_stall_wait", req_ready, 1'b0);
      check("w3_haddr_hold", haddr, 32'h200);
    end
    step(); hready = 1'b1;
    #1 check("w3_push_pop", req_ready, 1'b1);
    check("w3_haddr_last", haddr, 32'h200);
    step(); req_valid = 1'b0;
    #1 check("w3_ovl1_htrans", htrans, 2'b10);
    check("w3_ovl1_haddr", haddr, 32'h204);
    check("w3_d1", hwdata, 32'h1111_1111);
    step(); #1 check("w3_ovl2_haddr", haddr, 32'h208);
    check("w3_d2", hwdata, 32'h2222_2222);
    step(); #1 check("w3_tail_htrans", htrans, 2'b00);
    check("w3_d3", hwdata, 32'h3333_3333);
    check("w3_busy", wbuf_empty, 1'b0);
    step(); #1 check("w3_drained", wbuf_empty, 1'b1);

    // error response on a store with a pipelined follower
    req_valid = 1'b1; req_write = 1'b1; req_fn3 = 3'b010;
    req_addr = 32'h2000; req_wdata = 32'hAAAA_5555;
    step(); req_addr = 32'h2004; req_wdata = 32'h1234_5678;
    step(); req_valid = 1'b0;
    #1 check("err_haddr", haddr, 32'h2000);
    step(); hresp = 1'b1; hready = 1'b0;
    #1 check("err_c1_htrans", htrans, 2'b00);
    step(); hready = 1'b1;
    #1 check("err_c2_htrans", htrans, 2'b00);
    check("err_c2_wr_err", wr_err, 1'b0);
    step(); hresp = 1'b0;
    #1 check("err_wr_err", wr_err, 1'b1);
    step(); #1 check("err_reissue_htrans", htrans, 2'b10);
    check("err_reissue_haddr", haddr, 32'h2004);
    step(); #1 check("err_reissue_hwdata", hwdata, 32'h1234_5678);
    step();
    wr_err_clr = 1'b1;
    step(); wr_err_clr = 1'b0;
    #1 check("err_clr", wr_err, 1'b0);

    // misaligned store with a simultaneous clear
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h302; req_fn3 = 3'b010;
    wr_err_clr = 1'b1;
    #1 check("mis_sw_ready", req_ready, 1'b1);
    step(); req_valid = 1'b0; wr_err_clr = 1'b0;
    #1 check("mis_sw_clr_same", wr_err, 1'b1);
    check("mis_sw_htrans", htrans, 2'b00);
    check("mis_sw_empty", wbuf_empty, 1'b1);
    wr_err_clr = 1'b1;
    step(); wr_err_clr = 1'b0;
    #1 check("mis_sw_htrans2", htrans, 2'b00);
    check("mis_sw_cleared", wr_err, 1'b0);

    // misaligned halfword load
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h101; req_fn3 = 3'b001;
    #1 check("mis_lh_ready", req_ready, 1'b1);
    step(); req_valid = 1'b0;
    #1 check("mis_lh_valid", rsp_valid, 1'b1);
    check("mis_lh_err", rsp_err, 1'b1);
    check("mis_lh_htrans", htrans, 2'b00);
    step(); #1 check("mis_lh_done", rsp_valid, 1'b0);
    check("mis_lh_htrans2", htrans, 2'b00);

    // error response on a load
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_fn3 = 3'b010;
    #1 check("lerr_ready", req_ready, 1'b1);
    step(); req_valid = 1'b0;
    #1 check("lerr_htrans", htrans, 2'b10);
    step(); hresp = 1'b1; hready = 1'b0;
    #1 check("lerr_c1_valid", rsp_valid, 1'b0);
    step(); hready = 1'b1;
    #1 check("lerr_c2_valid", rsp_valid, 1'b1);
    check("lerr_c2_err", rsp_err, 1'b1);
    step(); hresp = 1'b0;
    #1 check("lerr_done", rsp_valid, 1'b0);
    check("lerr_wr_err", wr_err, 1'b0);

    // reset with a full buffer and a waited address phase
    req_valid = 1'b1; req_write = 1'b1; req_fn3 = 3'b010;
    req_addr = 32'h500; req_wdata = 32'h5555_0000;
    step(); req_addr = 32'h504; req_wdata = 32'h5555_0004;
    step(); hready = 1'b0;
    #1 check("rstm_busy", wbuf_empty, 1'b0);
    check("rstm_full", req_ready, 1'b0);
    step();
    reset = 1'b0;
    #1 check_reset("rstm");
    step(); req_valid = 1'b0; hready = 1'b1;
    reset = 1'b1;
    step(); step();
    #1 check("rstm_post_htrans", htrans, 2'b00);
    check("rstm_post_empty", wbuf_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_if.md
AHB_LITE_MASTER_IF -- requirements
Module: ahb_lite_master_if

Interface
REQ-001 Parameter ADDR_W, default 32: width of the request address and of haddr.
REQ-002 Parameter DATA_W, default 32: width of the data buses; legal values are 32 and 64.
REQ-003 Parameter WBUF_DEPTH, default 2: number of posted-write buffer entries; power of two, at least 1.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1: core memory request present.
REQ-007 Port req_ready, output, 1: request accepted this cycle.
REQ-008 Port req_write, input, 1: 1 = store, 0 = load.
REQ-009 Port req_addr, input, ADDR_W: byte address.
REQ-010 Port req_fn3, input, 3: RISC-V funct3 size and sign code.
REQ-011 Port req_wdata, input, DATA_W: store data, right-aligned.
REQ-012 Port rsp_valid, output, 1: one-cycle load-completion pulse.
REQ-013 Port rsp_rdata, output, DATA_W: aligned and extended load data.
REQ-014 Port rsp_err, output, 1: load error or misalignment; qualified by rsp_valid.
REQ-015 Port wr_err, output, 1: sticky posted-write error flag.
REQ-016 Port wr_err_clr, input, 1: clears wr_err.
REQ-017 Port wbuf_empty, output, 1: no posted write pending or in flight.
REQ-018 AHB master ports: haddr (ADDR_W), htrans (2), hwrite (1), hsize (3), hprot (4) and hwdata (DATA_W) are outputs; hready (1), hresp (1) and hrdata (DATA_W) are inputs.

Function
REQ-019 The bus FSM SHALL have states IDLE, ADDR, DATA and ERR2.
- IDLE to ADDR when the buffer is non-empty or a load is accepted.
- ADDR to DATA when hready is sampled high.
- DATA to ADDR when a next transfer is pending and hready is high.
- DATA to IDLE when nothing is pending and hready is high.
- DATA to ERR2 when hresp is high while hready is low.
- ERR2 to IDLE after one cycle.
REQ-020 htrans SHALL be NONSEQ (2'b10) in ADDR, or in DATA when it overlaps the next address phase, and IDLE (2'b00) otherwise.
- hburst is not generated; single transfers only.
REQ-021 The address phase SHALL hold haddr, hwrite, hsize and htrans stable while hready is low.
REQ-022 hwdata SHALL be driven in the data phase and held until hready is high.
- Byte stores are replicated to every byte lane.
- Halfword stores are replicated to every halfword lane.
REQ-023 hsize SHALL equal req_fn3[1:0] zero-extended.
- hprot SHALL be the constant 4'b0011.
REQ-024 A store SHALL be accepted (req_ready high) when the buffer is not full.
- No rsp_valid is produced for a store.
REQ-025 A load SHALL be accepted only when wbuf_empty is high and no load is outstanding, preserving program order.
REQ-026 On a load data phase with hready high, rsp_valid SHALL pulse in that same cycle.
- The lane is selected by haddr low bits and right-shifted.
- fn3 codes 000 and 001 are sign-extended; 100 and 101 are zero-extended.
REQ-027 Two-cycle error response:
- Cycle 1 (hresp=1, hready=0): htrans SHALL be IDLE, cancelling any overlapped address.
- Cycle 2 (hresp=1, hready=1): ends the transfer.
- For a load: rsp_valid=1 and rsp_err=1.
- For a store: wr_err is set.
REQ-028 A misaligned request SHALL generate no bus transfer.
- Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- A misaligned load produces rsp_valid=1 and rsp_err=1 in the cycle after acceptance.
- A misaligned store sets wr_err and is not buffered.
REQ-029 Buffer full, store push and head pop in the same cycle: the push SHALL be accepted.
- Buffer pointers wrap modulo WBUF_DEPTH.
REQ-030 If wr_err_clr is asserted in the same cycle as a new write error, wr_err SHALL remain set.

Reset
REQ-031 While reset is low, outputs SHALL be:
- htrans=IDLE; haddr, hwdata and hsize are 0; hwrite=0; hprot=4'b0011.
- req_ready=0; rsp_valid=0; rsp_err=0; wr_err=0; wbuf_empty=1.
- The FSM is in IDLE and the buffer is empty.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered and in-flight operations without a response.
REQ-033 The first transfer after release SHALL occur no earlier than the second rising edge of clk.

Structure
REQ-034 A shared package SHALL hold:
- the FSM state enum;
- the htrans encodings;
- the funct3 size and sign constants;
- the hprot constant.
REQ-035 The posted-write buffer SHALL be a sub-module, ahb_wbuf_fifo, parametrised by depth and entry width.

Verification
REQ-036 SW then LW to 0x100 with data 0xDEADBEEF and zero wait states: rsp_rdata=0xDEADBEEF, and the load address phase occurs no earlier than the store data phase.
REQ-037 LB from 0x103 with hrdata=0x80FF_FF00: rsp_rdata=0xFFFFFF80; the same access as LBU gives 0x00000080.
REQ-038 Three SW with WBUF_DEPTH=2 and hready low for 4 cycles: req_ready is low on the third store until the first store completes; haddr stays stable throughout.
REQ-039 Error on a store to 0x2000, followed by a pipelined SW: htrans is IDLE in error cycle 1, wr_err=1, and the second store is reissued afterwards.
REQ-040 LH from 0x101: no htrans NONSEQ, and rsp_valid=1 with rsp_err=1 one cycle after acceptance.
REQ-041 Reset asserted while hready is low and the buffer is full: all outputs return to reset values immediately, and wbuf_empty=1.
